max7219_if_arbiter: RTL
=======================

# max7219_if_arbiter

Round-robin arbiter sharing one `max7219_if` serial engine between up to `G_NB_REQ` frame producers, for example `max7219_scroller_ctrl`, a static-display controller and an init/config sequencer. A grant covers one complete daisy-chain transaction: all frames up to and including the frame with `en_load=1`. Frames from different requesters never interleave inside one LOAD window. The block sits between the requesters and `max7219_if`.

## Interface
Parameters:
- `G_NB_REQ`, default 3: number of requesters, 2..8.
- `G_DATA_WIDTH`, default 16: MAX7219 frame width.
- `G_TIMEOUT`, default 1024: clk cycles allowed between a forwarded start and `i_max7219_if_done`; 0 disables the watchdog.

Ports:
- `clk` in, 1: single clock, rising edge.
- `rst_n` in, 1: asynchronous active-low reset.
- `i_req` in, `G_NB_REQ`: level request per requester, held for the whole transaction.
- `o_gnt` in/out: out, `G_NB_REQ`: one-hot grant, registered.
- `i_req_start` in, `G_NB_REQ`: one-cycle frame start pulse per requester.
- `i_req_en_load` in, `G_NB_REQ`: frame closes the LOAD window (last frame of the transaction).
- `i_req_data` in, `G_NB_REQ*G_DATA_WIDTH`: frames, requester k at bits `[k*W +: W]`.
- `o_req_done` out, `G_NB_REQ`: one-cycle done pulse, routed to the granted requester only.
- `o_max7219_if_start` out, 1: start pulse to `max7219_if`.
- `o_max7219_if_en_load` out, 1: latched en_load.
- `o_max7219_if_data` out, `G_DATA_WIDTH`: latched frame.
- `i_max7219_if_done` in, 1: frame complete from `max7219_if`.
- `o_busy` out, 1: high whenever a grant is held.
- `o_err` out, 2: sticky flags. Bit 0: start from a non-granted requester, or a start while a frame is in flight. Bit 1: watchdog timeout. Cleared only by reset.

## Operation
- State machine: IDLE, GRANTED, FRAME, RELEASE.
- IDLE:
  - If any `i_req` is high, pick the first requester at or after `rr_ptr` (wrapping modulo `G_NB_REQ`).
  - Set the one-hot `o_gnt`, set `o_busy=1`, go to GRANTED.
- GRANTED:
  - `i_req_start[g]` latches `data[g]` and `en_load[g]`, pulses `o_max7219_if_start`, clears `last_seen`, loads the watchdog, then goes to FRAME.
  - If `i_req[g]` falls with no frame in flight, go to RELEASE (abort; no LOAD is issued).
- FRAME:
  - On `i_max7219_if_done`, pulse `o_req_done[g]`.
  - If the latched `en_load=1` or `i_req[g]=0`, go to RELEASE; otherwise go back to GRANTED.
  - If `i_req[g]` drops mid-frame, the frame still completes before release.
  - On watchdog expiry: set `o_err[1]`, emit no done pulse, go to RELEASE.
- RELEASE (1 cycle):
  - Clear `o_gnt` and `o_busy`.
  - Set `rr_ptr = (g+1) mod G_NB_REQ`.
  - Go to IDLE.
  - The same requester may win again only if no other requester is pending.
- Starts from non-granted requesters are dropped and set `o_err[0]`. A granted start while in FRAME is also dropped and sets `o_err[0]`.
- The watchdog is a 32-bit down-counter that is active only in FRAME.
- `o_max7219_if_data` and `o_max7219_if_en_load` hold their latched values until the next forwarded start.

## Timing
- Reset values:
  - State IDLE, `rr_ptr=0`.
  - All outputs 0: `o_gnt`, `o_req_done`, `o_max7219_if_start`, `o_max7219_if_en_load`, `o_max7219_if_data`, `o_busy`, `o_err`.
- Request to grant: `i_req` high at edge n gives `o_gnt` at n+1.
- Start forwarding: `i_req_start` at edge n gives `o_max7219_if_start` high for exactly one cycle at n+1, with data and en_load valid in the same cycle.
- Done forwarding: `i_max7219_if_done` at edge n gives `o_req_done[g]` at n+1.
  - Requester start at that same n+1 is accepted, because the state is back in GRANTED.
- Release to next grant: at least 2 cycles (RELEASE, then IDLE evaluation).
- Simultaneous done and `i_req` drop: the done pulse is still delivered, then release.
- Reset asserted mid-frame: outputs clear immediately (asynchronous reset); any frame in progress inside `max7219_if` is not the arbiter's concern.

## Structure
- Shared package `max7219_pkg`:
  - `C_MAX7219_FRAME_WIDTH = 16`.
  - `t_arb_state` enum.
  - Error bit indices `C_ERR_START = 0`, `C_ERR_TIMEOUT = 1`.
- Sub-module `rr_picker`: combinational round-robin search over `i_req` from `rr_ptr`, producing a one-hot result plus a valid flag. It can be reused by other shared resources.

## Test plan
- Single requester: req0 sends 8 frames, the first 7 with `en_load=0` and the 8th with `en_load=1`. Required:
  - 8 forwarded starts with matching data.
  - 8 `o_req_done[0]` pulses.
  - `o_gnt` drops 1 cycle after the 8th done.
  - `MAX7219_LOAD` pulses once.
- Contention: req0, req1 and req2 all raise `i_req` in the same cycle, each sending a 2-frame transaction. Required:
  - Grant order 0, 1, 2.
  - No interleaving between transactions.
  - `rr_ptr` ends at 0.
- Fairness: req0 re-requests immediately after each release while req1 is also pending. Required: grants alternate 0, 1, 0, 1.
- Illegal start: req1 pulses start with data 0x0C01 while req0 holds the grant. Required:
  - No forwarded start.
  - `o_err[0]=1`.
  - req0's transaction completes unaffected.
- Timeout: `G_TIMEOUT=16`, `i_max7219_if_done` held low. Required:
  - `o_err[1]` is set 16 cycles after the start.
  - Grant released.
  - No `o_req_done` pulse.
- Abort and reset:
  - req0 drops `i_req` mid-frame: the frame completes, done is delivered, then release.
  - `rst_n` pulsed low mid-frame: all outputs are 0 within the same cycle.

Source files
------------

// File: rtl/max7219_pkg.sv
// Shared types and constants for the MAX7219 display path: frame width,
// arbiter state encoding and sticky error bit positions.
package max7219_pkg;

    localparam int C_MAX7219_FRAME_WIDTH = 16;

    localparam int C_ERR_START   = 0;
    localparam int C_ERR_TIMEOUT = 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANTED = 2'd1,
        S_FRAME   = 2'd2,
        S_RELEASE = 2'd3
    } t_arb_state;

    // Modulo-n wrap for an index known to be below 2*n.
    function automatic int wrap_idx(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/max7219_if_arbiter_rr_picker.sv
// Combinational round-robin search: first asserted request at or after the
// pointer, wrapping, returned as one-hot, index and valid flag.
module rr_picker
    import max7219_pkg::*;
#(
    parameter int G_N  = 3,
    parameter int G_PW = $clog2(G_N)
) (
    input  logic [G_N-1:0]  i_req,
    input  logic [G_PW-1:0] i_ptr,
    output logic [G_N-1:0]  o_onehot,
    output logic [G_PW-1:0] o_idx,
    output logic            o_valid
);

    logic [G_PW-1:0] cand_s;
    logic [G_PW-1:0] sel_s;

    // Scan from farthest to nearest so the nearest hit is the one kept.
    always_comb begin
        cand_s   = '0;
        sel_s    = '0;
        o_valid  = 1'b0;
        o_onehot = '0;
        for (int off = G_N - 1; off >= 0; off--) begin
            cand_s  = G_PW'(wrap_idx(int'(i_ptr) + off, G_N));
            sel_s   = i_req[cand_s] ? cand_s : sel_s;
            o_valid = o_valid | i_req[cand_s];
        end
        o_onehot[sel_s] = o_valid;
        o_idx           = sel_s;
    end

endmodule

// File: rtl/max7219_if_arbiter.sv
// Round-robin arbiter sharing one max7219_if serial engine between several
// frame producers; a grant spans a whole transaction up to the en_load frame.
module max7219_if_arbiter
    import max7219_pkg::*;
#(
    parameter int G_NB_REQ     = 3,
    parameter int G_DATA_WIDTH = C_MAX7219_FRAME_WIDTH,
    parameter int G_TIMEOUT    = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [G_NB_REQ-1:0]              i_req,
    output logic [G_NB_REQ-1:0]              o_gnt,
    input  logic [G_NB_REQ-1:0]              i_req_start,
    input  logic [G_NB_REQ-1:0]              i_req_en_load,
    input  logic [G_NB_REQ*G_DATA_WIDTH-1:0] i_req_data,
    output logic [G_NB_REQ-1:0]              o_req_done,
    output logic                             o_max7219_if_start,
    output logic                             o_max7219_if_en_load,
    output logic [G_DATA_WIDTH-1:0]          o_max7219_if_data,
    input  logic                             i_max7219_if_done,
    output logic                             o_busy,
    output logic [1:0]                       o_err
);

    localparam int          C_PW        = $clog2(G_NB_REQ);
    localparam logic [31:0] C_WDOG_LOAD = (G_TIMEOUT > 0) ? 32'(G_TIMEOUT - 1) : 32'd0;

    t_arb_state              state_q, state_d;
    logic [G_NB_REQ-1:0]     gnt_q, gnt_d;
    logic [C_PW-1:0]         gidx_q, gidx_d;
    logic [C_PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic                    busy_q, busy_d;
    logic                    start_q, start_d;
    logic                    en_load_q, en_load_d;
    logic [G_DATA_WIDTH-1:0] data_q, data_d;
    logic [G_NB_REQ-1:0]     done_q, done_d;
    logic [1:0]              err_q, err_d;
    logic [31:0]             wdog_q, wdog_d;

    logic [G_NB_REQ-1:0]     pick_onehot_s;
    logic [C_PW-1:0]         pick_idx_s;
    logic                    pick_valid_s;
    logic                    req_g_s;
    logic                    start_g_s;
    logic                    wdog_expired_s;
    logic [G_NB_REQ-1:0]     accept_mask_s;
    logic                    stray_start_s;

    rr_picker #(
        .G_N  (G_NB_REQ),
        .G_PW (C_PW)
    ) u_picker (
        .i_req    (i_req),
        .i_ptr    (rr_ptr_q),
        .o_onehot (pick_onehot_s),
        .o_idx    (pick_idx_s),
        .o_valid  (pick_valid_s)
    );

    assign req_g_s        = i_req[gidx_q];
    assign start_g_s      = i_req_start[gidx_q];
    assign wdog_expired_s = (G_TIMEOUT != 0) && (wdog_q == 32'd0);
    // Only the granted requester in GRANTED may start; anything else is dropped.
    assign accept_mask_s  = (state_q == S_GRANTED) ? gnt_q : '0;
    assign stray_start_s  = |(i_req_start & ~accept_mask_s);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            gidx_q    <= '0;
            rr_ptr_q  <= '0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            en_load_q <= 1'b0;
            data_q    <= '0;
            done_q    <= '0;
            err_q     <= 2'b00;
            wdog_q    <= 32'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gidx_q    <= gidx_d;
            rr_ptr_q  <= rr_ptr_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            en_load_q <= en_load_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wdog_q    <= wdog_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                state_d = pick_valid_s ? S_GRANTED : S_IDLE;
            end
            S_GRANTED: begin
                if (start_g_s) begin
                    state_d = S_FRAME;
                end else if (!req_g_s) begin
                    state_d = S_RELEASE;
                end else begin
                    state_d = S_GRANTED;
                end
            end
            S_FRAME: begin
                // Done wins over a simultaneous watchdog expiry.
                if (i_max7219_if_done) begin
                    state_d = (en_load_q || !req_g_s) ? S_RELEASE : S_GRANTED;
                end else if (wdog_expired_s) begin
                    state_d = S_RELEASE;
                end else begin
                    state_d = S_FRAME;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output and datapath next values.
    always_comb begin
        gnt_d     = gnt_q;
        gidx_d    = gidx_q;
        rr_ptr_d  = rr_ptr_q;
        busy_d    = busy_q;
        start_d   = 1'b0;
        en_load_d = en_load_q;
        data_d    = data_q;
        done_d    = '0;
        err_d     = err_q;
        wdog_d    = wdog_q;
        err_d[C_ERR_START] = err_q[C_ERR_START] | stray_start_s;
        case (state_q)
            S_IDLE: begin
                gnt_d  = pick_onehot_s;
                gidx_d = pick_idx_s;
                busy_d = pick_valid_s;
            end
            S_GRANTED: begin
                if (start_g_s) begin
                    start_d   = 1'b1;
                    data_d    = i_req_data[gidx_q*G_DATA_WIDTH +: G_DATA_WIDTH];
                    en_load_d = i_req_en_load[gidx_q];
                    wdog_d    = C_WDOG_LOAD;
                end else begin
                    wdog_d    = wdog_q;
                end
            end
            S_FRAME: begin
                if (i_max7219_if_done) begin
                    done_d = gnt_q;
                end else if (wdog_expired_s) begin
                    err_d[C_ERR_TIMEOUT] = 1'b1;
                end else if (G_TIMEOUT != 0) begin
                    wdog_d = wdog_q - 32'd1;
                end else begin
                    wdog_d = wdog_q;
                end
            end
            S_RELEASE: begin
                gnt_d    = '0;
                busy_d   = 1'b0;
                rr_ptr_d = (gidx_q == C_PW'(G_NB_REQ - 1)) ? '0 : gidx_q + C_PW'(1);
            end
            default: begin
                gnt_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign o_gnt                = gnt_q;
    assign o_busy               = busy_q;
    assign o_req_done           = done_q;
    assign o_max7219_if_start   = start_q;
    assign o_max7219_if_en_load = en_load_q;
    assign o_max7219_if_data    = data_q;
    assign o_err                = err_q;

endmodule
